// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: queue entry layout, NOP encoding and
// the 5-bit major opcodes the control unit decodes from instr[6:2].
package fetch_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pred_taken;
  } fq_entry_t;

  // addi x0,x0,0 -- decodes as a harmless IARTH op
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [4:0] RTYPE  = 5'b01100;
  localparam logic [4:0] IARTH  = 5'b00100;
  localparam logic [4:0] LOAD   = 5'b00000;
  localparam logic [4:0] STORE  = 5'b01000;
  localparam logic [4:0] BRANCH = 5'b11000;
  localparam logic [4:0] AUIPC  = 5'b00101;
  localparam logic [4:0] LUI    = 5'b01101;
  localparam logic [4:0] JAL    = 5'b11011;
  localparam logic [4:0] JALR   = 5'b11001;
  localparam logic [4:0] CSR    = 5'b11100;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode. Pointer pair with a
// wrap bit; head is a combinational read so a push at edge N shows at N+1.
// Redirect flush empties the queue in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  input  logic                     in_pred_taken,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic                     out_pred_taken,
  output logic [4:0]               out_op,
  output logic [1:0]               out_funct3,
  output logic                     out_bad_len,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Local entry type tracks the module XLEN (package type is fixed at 32).
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pred_taken;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic            empty, full, push, pop;
  entry_t          head;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign count = wptr - rptr;

  // in_ready ignores pop on purpose: no same-cycle refill when full.
  assign in_ready  = !full && !rst;
  assign push      = in_valid && in_ready && !flush;
  assign out_valid = !empty && !flush && !rst;
  assign pop       = out_valid && out_ready;

  // Storage write; contents are never reset, only the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= '{pc: in_pc, instr: in_instr, pred_taken: in_pred_taken};
  end

  // Pointer update: rst > flush > push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  assign head = mem[rptr[AW-1:0]];

  // Head outputs; substitute a NOP whenever decode must not see an entry.
  always_comb begin
    out_pc         = '0;
    out_instr      = XLEN'(NOP_INSTR);
    out_pred_taken = 1'b0;
    if (out_valid) begin
      out_pc         = head.pc;
      out_instr      = head.instr;
      out_pred_taken = head.pred_taken;
    end
  end

  assign out_op      = out_instr[6:2];
  assign out_funct3  = out_instr[13:12];
  assign out_bad_len = out_valid && (out_instr[1:0] != 2'b11);

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench: stimulus pushes accepted entries into an expected queue,
// a monitor compares every cycle's outputs against that queue and pops on
// each handshake.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pt;
  } ent_t;

  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0, in_ready;
  logic [XLEN-1:0] in_pc = 0, in_instr = 0;
  logic in_pred_taken = 0;
  logic out_valid, out_ready = 0;
  logic [XLEN-1:0] out_pc, out_instr;
  logic out_pred_taken, out_bad_len;
  logic [4:0] out_op;
  logic [1:0] out_funct3;
  logic flush = 0;
  logic [CW-1:0] count;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_pred_taken(in_pred_taken),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_pred_taken(out_pred_taken),
    .out_op(out_op), .out_funct3(out_funct3), .out_bad_len(out_bad_len),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  ent_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   started = 0;
  int   max_seen = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare outputs against the expected queue every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (started) begin
        bit ev;
        ev = (exp_q.size() > 0) && !flush && !rst;
        chk("count",     64'(count),    64'(exp_q.size()));
        chk("in_ready",  64'(in_ready), 64'((exp_q.size() < DEPTH) && !rst));
        chk("out_valid", 64'(out_valid), 64'(ev));
        if (ev) begin
          ent_t e;
          e = exp_q[0];
          chk("out_pc",     64'(out_pc),         64'(e.pc));
          chk("out_instr",  64'(out_instr),      64'(e.instr));
          chk("out_pred",   64'(out_pred_taken), 64'(e.pt));
          chk("out_op",     64'(out_op),         64'(e.instr[6:2]));
          chk("out_funct3", 64'(out_funct3),     64'(e.instr[13:12]));
          chk("out_badlen", 64'(out_bad_len),    64'(e.instr[1:0] != 2'b11));
          if (out_ready) void'(exp_q.pop_front());
        end else begin
          chk("nop_pc",     64'(out_pc),         64'(0));
          chk("nop_instr",  64'(out_instr),      64'(32'h0000_0013));
          chk("nop_pred",   64'(out_pred_taken), 64'(0));
          chk("nop_op",     64'(out_op),         64'(5'b00100));
          chk("nop_funct3", 64'(out_funct3),     64'(0));
          chk("nop_badlen", 64'(out_bad_len),    64'(0));
        end
      end
    end
  end

  // One cycle of stimulus; acc reports whether the entry was accepted.
  task automatic step(input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                      input bit pt, input bit ordy, input bit fl, input bit r,
                      output bit acc);
    @(negedge clk);
    in_valid = iv; in_pc = pc; in_instr = ins; in_pred_taken = pt;
    out_ready = ordy; flush = fl; rst = r;
    #1;
    acc = iv && !r && !fl && (exp_q.size() < DEPTH);
    @(posedge clk);
    if (r || fl) exp_q.delete();
    else if (acc) exp_q.push_back('{pc: pc, instr: ins, pt: pt});
    if (exp_q.size() > max_seen) max_seen = exp_q.size();
  endtask

  logic [31:0] fill_instr [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013};

  initial begin
    bit a;
    logic [31:0] pc;
    // reset
    step(0, 0, 0, 0, 0, 0, 1, a);
    started = 1;
    step(0, 0, 0, 0, 0, 0, 1, a);
    step(0, 0, 0, 0, 0, 0, 0, a);

    // fill to full, then try a 5th push while full
    for (int i = 0; i < 4; i++) step(1, 32'(i*4), fill_instr[i], 0, 0, 0, 0, a);
    step(1, 32'h10, 32'h00000013, 0, 0, 0, 0, a);
    chk("full_reject", 64'(a), 64'(0));
    // full with pop requested: still no same-cycle refill
    step(1, 32'h10, 32'h00000013, 0, 1, 0, 0, a);
    chk("full_pop_reject", 64'(a), 64'(0));

    // drain the rest
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0, a);

    // fill 2, then 10 cycles simultaneous push/pop
    pc = 32'h100;
    for (int i = 0; i < 2; i++) begin step(1, pc, 32'h00000033, 0, 0, 0, 0, a); pc += 4; end
    for (int i = 0; i < 10; i++) begin
      step(1, pc, 32'h00208033 | 32'(i << 7), i[0], 1, 0, 0, a);
      pc += 4;
    end

    // flush at count=3 with push and pop requested
    step(0, 0, 0, 0, 0, 0, 0, a);
    step(1, pc, 32'h00000013, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 0, 0, 0, a);
    chk("pre_flush_count", 64'(count), 64'(3));
    step(1, 32'h40, 32'h00000013, 0, 1, 1, 0, a);
    step(0, 0, 0, 0, 1, 1, 0, a);   // back-to-back flush
    step(0, 0, 0, 0, 1, 0, 0, a);

    // bad length + prediction bit
    step(1, 32'h200, 32'h00004501, 1, 0, 0, 0, a);
    step(0, 0, 0, 0, 1, 0, 0, a);
    step(0, 0, 0, 0, 0, 0, 0, a);

    // reset mid-traffic at count=3
    for (int i = 0; i < 3; i++) step(1, 32'h300 + 32'(i*4), 32'h00000013, 0, 0, 0, 0, a);
    step(1, 32'h30C, 32'h00000013, 0, 0, 0, 1, a);
    step(1, 32'h30C, 32'h00000013, 0, 0, 0, 1, a);
    step(0, 0, 0, 0, 0, 0, 0, a);

    // randomized traffic; producer holds its item until accepted
    begin
      logic [31:0] rpc, rins;
      bit rpt, iv;
      rpc = 32'h1000; rins = $urandom; rpt = 1'($urandom);
      for (int i = 0; i < 400; i++) begin
        iv = ($urandom_range(3) != 0);
        step(iv, rpc, rins, rpt, ($urandom_range(2) != 0),
             ($urandom_range(29) == 0), ($urandom_range(99) == 0), a);
        if (a) begin rpc += 4; rins = $urandom; rpt = 1'($urandom); end
      end
    end
    step(0, 0, 0, 0, 1, 0, 0, a);
    chk("reached_full", 64'(max_seen), 64'(DEPTH));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small circular instruction queue between the fetch stage (imem response plus perceptron prediction) and the decode stage.
- Decouples imem timing from decode stalls.
- Supplies decode with pc, instr, predicted-taken bit and the pre-sliced opcode and funct3 fields consumed by the control unit.
- A redirect flush (branch mispredict, jump or trap) discards every queued entry in one cycle.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- XLEN, 32, width of pc and instr.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  queue can accept an entry this cycle.
- in_pc  in  XLEN  pc of the fetched instruction.
- in_instr  in  XLEN  raw instruction word.
- in_pred_taken  in  1  predictor taken bit for this pc.
- out_valid  out  1  head entry valid for decode.
- out_ready  in  1  decode consumes the head this cycle.
- out_pc  out  XLEN  head pc.
- out_instr  out  XLEN  head instruction; NOP when out_valid=0.
- out_pred_taken  out  1  head prediction bit.
- out_op  out  5  out_instr[6:2], feeds the control unit op input.
- out_funct3  out  2  out_instr[13:12], feeds the control unit funct3 input.
- out_bad_len  out  1  out_valid & (out_instr[1:0] != 2'b11); non-32-bit encoding.
- flush  in  1  discard all entries; in-cycle push and pop are ignored.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage and pointers
  - DEPTH-entry array of {pc, instr, pred_taken}.
  - wptr and rptr are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = (wptr == rptr); full = index bits equal and MSBs differ.
  - count = wptr - rptr, modulo 2^($clog2(DEPTH)+1).
- Handshake
  - in_ready = !full & !rst.
  - push = in_valid & in_ready & !flush.
  - out_valid = !empty & !flush.
  - pop = out_valid & out_ready.
  - in_* are sampled only on push.
  - Producer must hold in_* stable while in_valid=1 and in_ready=0.
- Latency
  - An entry pushed at edge N is visible at out_* in cycle N+1. There is no combinational in-to-out bypass.
  - Head outputs are a combinational read of array[rptr]; no extra register.
- Simultaneous push and pop
  - Non-full, non-empty: both pointers advance and count is unchanged.
  - When full, in_ready=0 even if pop is asserted. There is no same-cycle refill, which keeps in_ready free of out_ready paths.
- Empty queue outputs
  - out_instr = 32'h0000_0013 (addi x0,x0,0), so the control unit decodes a harmless op.
  - out_pc = 0, out_pred_taken = 0, out_bad_len = 0.
  - out_op and out_funct3 follow out_instr: 5'b00100 and 2'b00.
- Flush
  - Effect at the next edge: wptr = rptr = 0, count = 0.
  - Any push or pop in the flush cycle is discarded.
  - out_valid is forced 0 combinationally during the flush cycle.
  - Back-to-back flush cycles are allowed.
- Wrap-around
  - Pointers increment modulo 2^($clog2(DEPTH)+1).
  - Index = low $clog2(DEPTH) bits.
  - Full and empty must stay correct after arbitrarily many wraps.
- Reset
  - At the rst edge: wptr = rptr = 0 and count = 0.
  - During and after reset: out_valid = 0, outputs take the empty-queue values, and in_ready = 0 while rst=1, then 1.
  - Array contents are not reset.
  - Reset during traffic aborts it; the first cycle after rst deasserts behaves like an empty queue.
- Precedence: rst > flush > push/pop.
- No state machine beyond the pointer pair; all control derives from full, empty and flush.

Decomposition:
- fetch_pkg holds:
  - fq_entry_t struct {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr; logic pred_taken;}.
  - NOP_INSTR = 32'h0000_0013.
  - The 5-bit opcode constants shared with the control unit (RTYPE, IARTH, LOAD, STORE, BRANCH, AUIPC, LUI, JAL, JALR, CSR).
- No sub-module. The pointer logic and the array live in fetch_queue itself; a generic FIFO would obscure the flush and NOP semantics.

Test Plan:
- Fill to full:
  - Stimulus: reset, then push pc=0x0/0x4/0x8/0xC with instr 0x00500093,0x00A00113,0x002081B3,0x00000013, holding out_ready=0.
  - Response: count goes 1..4, in_ready=0 after the 4th push, and out_pc=0x0 with out_op=5'b00100 from the cycle after the 1st push.
- Drain in order:
  - Stimulus: from full, set out_ready=1 for 4 cycles.
  - Response: out_pc 0x0,0x4,0x8,0xC in order, then out_valid=0 and out_instr=0x00000013.
  - out_funct3 = 2'b00 on the R-type add (0x002081B3).
- Simultaneous push and pop at count=2 for 10 cycles:
  - Response: count stays 2, pointers wrap at least twice, FIFO order is preserved, no entry is lost or duplicated.
- Flush:
  - Stimulus: count=3, assert flush together with in_valid=1 (pc=0x40) and out_ready=1.
  - Response: out_valid=0 in the flush cycle; next cycle count=0 and out_valid=0; pc=0x40 never appears.
- Bad length and prediction bit:
  - Stimulus: push instr=0x00004501 with in_pred_taken=1.
  - Response: out_bad_len=1 and out_pred_taken=1 on the head.
- Reset mid-traffic:
  - Stimulus: rst=1 at count=3 while in_valid=1.
  - Response: in_ready=0 and out_valid=0 while rst=1; after release count=0 and in_ready=1.
